// File: rtl/uart_receiver.sv
// uart_receiver: 2-flop synced UART RX (5-8 data bits, optional even parity, 1/2 stops); define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  two_stop_bits,
  input  logic [1:0]            word_length,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);
  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int TW       = $clog2(BIT_CYC + 1);
  localparam int IW       = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] BIT_END  = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_CYC - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_nx;
  logic rx_m, rx_s, bit_s, armed, par_q, two_q, perr, ferr, tick, last, start, done;
  logic [1:0] wl_q;
  logic [TW-1:0] timer;
  logic [IW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  always_ff @(posedge clk) begin
    if (rst) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {rx, rx_m};
  end
`ifdef UART_RX_MAJORITY_EN
  logic rx_p;
  always_ff @(posedge clk) rx_p <= rst ? 1'b1 : rx_s;
  // rx_m is next cycle's rx_s, so the late vote needs no extra decision latency
  assign bit_s = (rx_p & rx_s) | (rx_p & rx_m) | (rx_s & rx_m);
`else
  assign bit_s = rx_s;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? START : IDLE;
      START:   if (tick) state_nx = rx_s ? IDLE : DATA;
      DATA:    if (tick && last) state_nx = par_q ? PARITY : STOP1;
      PARITY:  if (tick) state_nx = STOP1;
      STOP1:   if (tick) state_nx = two_q ? STOP2 : IDLE;
      STOP2:   if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    rx_busy = state != IDLE;
    tick    = timer == ((state == START) ? HALF_END : BIT_END);
    last    = bit_idx == IW'(3'd4 + {1'b0, wl_q});
    start   = state == IDLE && armed && !rx_s;
    done    = tick && (state == STOP2 || (state == STOP1 && !two_q));
  end
  // armed blocks a held-low line (break) from re-triggering until it is seen idle
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      par_q      <= 1'b0;
      two_q      <= 1'b0;
      wl_q       <= 2'b0;
      armed      <= 1'b1;
    end else begin
      timer      <= (state == IDLE || tick) ? '0 : timer + 1'b1;
      data_valid <= done;
      armed      <= done ? 1'b0 : (state == IDLE && rx_s) ? 1'b1 : armed;
      if (start) begin
        {par_q, two_q, wl_q} <= {parity_en, two_stop_bits, word_length};
        shreg   <= '0;
        bit_idx <= '0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
      end
      if (tick && state == DATA) begin
        shreg[bit_idx] <= bit_s;
        bit_idx        <= bit_idx + 1'b1;
      end
      if (tick && state == PARITY) perr <= bit_s ^ (^shreg);
      if (tick && state == STOP1) ferr <= !bit_s;
      if (done) begin
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= ferr | !bit_s;
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: random and directed frames scored against a frame-level reference model
module tb_uart_receiver;
  localparam int BIT = 20, HALF = 10;
  logic clk = 0, rst = 1, rx = 1, parity_en = 0, two_stop_bits = 0;
  logic [1:0] word_length = 2'd3;
  logic [7:0] data_out;
  logic data_valid, parity_err, frame_err, rx_busy;
  int cyc = 0, checks = 0, errors = 0, t0;
  typedef struct {logic [7:0] d; logic p; logic f; int when;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] rd;
  logic [1:0] rwl;
  logic rpe, rts, rpb, rs1, rs2;

  uart_receiver #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(50_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .parity_en(parity_en), .two_stop_bits(two_stop_bits),
    .word_length(word_length), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Frame-level model: masked word, even-parity check, stop-bit check, and the
  // pulse cycle = line start + 2 sync + 1 detect + half bit + one bit per sampled bit.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] wl,
                                 input logic pe, ts, pbit, s1, s2, input int start);
    exp_t r;
    int n = 5 + int'(wl);
    logic [7:0] m = 8'((1 << n) - 1);
    r.d = d & m;
    r.p = pe & (pbit ^ (^(d & m)));
    r.f = !s1 || (ts && !s2);
    r.when = start + 3 + HALF + (n + int'(pe) + 1 + int'(ts)) * BIT;
    return r;
  endfunction

  always @(negedge clk) if (!rst) begin
    if (data_valid) begin
      if (exp_q.size() == 0) chk("unexpected data_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("valid cycle", cyc, e.when);
        chk("data_out", int'(data_out), int'(e.d));
        chk("parity_err", int'(parity_err), int'(e.p));
        chk("frame_err", int'(frame_err), int'(e.f));
      end
    end else if (exp_q.size() != 0 && cyc >= exp_q[0].when) begin
      chk("missing data_valid", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    rx = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic [1:0] wl, input logic pe, ts, pbit, s1, s2,
                       input bit scramble, input int abort_at);
    int n = 5 + int'(wl);
    logic line[$];
    line.push_back(1'b0);
    for (int i = 0; i < n; i++) line.push_back(d[i]);
    if (pe) line.push_back(pbit);
    line.push_back(s1);
    if (ts) line.push_back(s2);
    {parity_en, two_stop_bits, word_length} = {pe, ts, wl};
    @(posedge clk);
    #1;
    if (abort_at < 0) exp_q.push_back(model(d, wl, pe, ts, pbit, s1, s2, cyc));
    foreach (line[j]) begin
      rx = line[j];
      if (scramble && j == 1) {parity_en, two_stop_bits, word_length} = 4'($urandom);
      if (j == abort_at) begin
        repeat (HALF) @(posedge clk);
        #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rx_busy", int'(rx_busy), 0);
        chk("rst data_valid", int'(data_valid), 0);
        chk("rst data_out", int'(data_out), 0);
        rst = 0;
        rx = 1;
        return;
      end
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", int'(data_out), 0);
    chk("reset data_valid", int'(data_valid), 0);
    chk("reset parity_err", int'(parity_err), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset rx_busy", int'(rx_busy), 0);
    rst = 0;
    idle(5);
    frame(8'h55, 2'd3, 0, 0, 0, 1, 1, 0, -1); idle(3);
    chk("8N1 0x55 data", int'(data_out), 'h55);
    chk("8N1 0x55 frame_err", int'(frame_err), 0);
    frame(8'h41, 2'd3, 1, 0, 0, 1, 1, 0, -1); idle(3);
    chk("8E1 0x41 data", int'(data_out), 'h41);
    chk("8E1 0x41 parity_err", int'(parity_err), 0);
    frame(8'h43, 2'd3, 1, 0, 0, 1, 1, 0, -1); idle(3);
    chk("8E1 0x43 data", int'(data_out), 'h43);
    chk("8E1 0x43 parity_err", int'(parity_err), 1);
    frame(8'h0F, 2'd0, 0, 0, 0, 1, 1, 0, -1); idle(3);
    chk("5N1 data", int'(data_out), 'h0F);
    frame(8'h7F, 2'd2, 0, 1, 0, 1, 1, 0, -1); idle(3);
    chk("7N2 data", int'(data_out), 'h7F);
    chk("7N2 frame_err", int'(frame_err), 0);
    frame(8'hAA, 2'd3, 0, 0, 0, 0, 1, 0, -1); idle(3);
    chk("stop low data", int'(data_out), 'hAA);
    chk("stop low frame_err", int'(frame_err), 1);
    // break: line held low well past the stop bit
    {parity_en, two_stop_bits, word_length} = {1'b0, 1'b0, 2'd3};
    @(posedge clk);
    #1;
    t0 = cyc;
    exp_q.push_back('{d: 8'h00, p: 1'b0, f: 1'b1, when: t0 + 3 + HALF + 9 * BIT});
    rx = 0;
    repeat (13 * BIT) @(posedge clk);
    #1;
    chk("break rx_busy", int'(rx_busy), 0);
    chk("break data", int'(data_out), 0);
    chk("break frame_err", int'(frame_err), 1);
    idle(5);
    // short low glitch on idle line
    @(posedge clk);
    #1;
    t0 = cyc;
    rx = 0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1;
    chk("glitch rx_busy high", int'(rx_busy), 1);
    repeat (HALF - 1) @(posedge clk);
    #1;
    chk("glitch rx_busy low", int'(rx_busy), 0);
    idle(5);
    frame(8'hC3, 2'd3, 0, 0, 0, 1, 1, 0, 4);
    frame(8'h3C, 2'd3, 0, 0, 0, 1, 1, 0, -1); idle(3);
    chk("after reset data", int'(data_out), 'h3C);
    repeat (60) begin
      rd = 8'($urandom);
      rwl = 2'($urandom);
      rpe = 1'($urandom);
      rts = 1'($urandom);
      rpb = 1'($urandom);
      rs1 = $urandom_range(0, 7) != 0;
      rs2 = $urandom_range(0, 7) != 0;
      frame(rd, rwl, rpe, rts, rpb, rs1, rs2, 1, -1);
      idle($urandom_range(2, 25));
    end
    idle(30);
    chk("pending expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum received word width.
REQ-002 SHALL have parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, bit rate; BIT_CYC = CLK_FREQ/BAUD_RATE (integer divide), HALF_CYC = BIT_CYC/2.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port parity_en  input  1  1 = even parity bit expected after data.
REQ-008 SHALL have port two_stop_bits  input  1  1 = two stop bits expected.
REQ-009 SHALL have port word_length  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  last received word, LSB first on the line, unused upper bits zero.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse, data_out and error flags valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on the word flagged by data_valid.
REQ-013 SHALL have port frame_err  output  1  a stop bit sampled low on the word flagged by data_valid.
REQ-014 SHALL have port rx_busy  output  1  high in every state other than IDLE.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer initialised to 1; all decisions use the synchronized value rx_s.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP1 and STOP2 with a bit-timer counter and a bit index.
REQ-017 SHALL, in IDLE, on rx_s == 0, latch parity_en, two_stop_bits and word_length, clear the timer and enter START; config changes mid-frame SHALL be ignored.
REQ-018 SHALL, in START, sample rx_s when timer == HALF_CYC-1; if 0, go to DATA and restart the timer; if 1, treat as a glitch and return to IDLE with no data_valid.
REQ-019 SHALL, in DATA, sample at every timer == BIT_CYC-1 (mid-bit) into bit index 0..N-1, where N = 5 + word_length.
REQ-020 SHALL, after bit N-1, go to PARITY if the latched parity_en is 1, else go to STOP1.
REQ-021 SHALL, in PARITY, sample the bit; parity_err = sampled bit XOR (XOR of the N data bits).
REQ-022 SHALL, in STOP1, sample the bit; a 0 sets frame_err; then go to STOP2 if two_stop_bits is latched, else finish.
REQ-023 SHALL, in STOP2, sample the bit; a 0 sets frame_err; then finish.
REQ-024 SHALL, on finish, update data_out, parity_err and frame_err and pulse data_valid on the cycle after the final mid-stop sample, then enter IDLE on that same cycle; this allows a back-to-back start edge half a bit later.
REQ-025 SHALL hold data_out, parity_err and frame_err stable until the next data_valid; data_valid SHALL also pulse on frames that carry errors.
REQ-026 SHALL, when rx_s stays low through the stop bit (break), report frame_err=1 and data_out=0, and SHALL not start a new frame until rx_s has been seen high in IDLE.

Reset
REQ-027 SHALL, while rst is high at a clock edge, force state IDLE, timer 0, bit index 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, rx_busy 0 and synchronizer flops 1.
REQ-028 SHALL, on rst mid-frame, abandon the frame with no data_valid pulse, and resume start detection on the first cycle after rst falls.

Configuration
REQ-029 SHALL support the macro UART_RX_MAJORITY_EN.
- Defined: each data, parity and stop bit is the 2-of-3 majority of rx_s at timer BIT_CYC-2, BIT_CYC-1 and BIT_CYC; the START check is unchanged.
- Undefined: single sample at BIT_CYC-1; the majority logic SHALL be absent.
- The data_valid timing SHALL be identical in both builds.

Verification
REQ-030 SHALL cover: 8N1 frame carrying 0x55 at 9600 baud, 100 MHz -> one data_valid, data_out=0x55, parity_err=0, frame_err=0.
REQ-031 SHALL cover: 8E1 frames 0x41 (parity bit 0), then 0x43 with parity bit 0 -> 0x41 with parity_err=0, then 0x43 with parity_err=1.
REQ-032 SHALL cover: 5N1 with line bits 1,1,1,1,0 followed by 7N2 carrying 0x7F -> data_out=0x0F, then data_out=0x7F, no errors.
REQ-033 SHALL cover: 8N1 carrying 0xAA with the stop bit driven low -> data_valid with data_out=0xAA and frame_err=1.
REQ-034 SHALL cover: a 2000-cycle low glitch on idle rx -> no data_valid, rx_busy returns low within HALF_CYC+3 cycles.
REQ-035 SHALL cover: rst asserted during data bit 3, then a clean 0x3C frame -> no pulse for the aborted frame, then data_out=0x3C.
